card_slot_sched: RTL and testbench

- Frame-synchronous scheduler between the blackjack game FSMs and the card-drawing stages of the VGA pipeline.
- Two requesters, player and dealer, submit card codes over a req/ack handshake. A round-robin arbiter grants at most one per cycle, and each granted card goes into the next free slot of that requester's hand in a shadow table.
- The shadow table is copied into the active table on the rising edge of vertical blanking, so draw stages never see a hand change mid-frame.

---
 rtl/card_slot_sched_if.sv | 12 +
 rtl/card_slot_sched.sv | 130 +++++++++++++
 tb/tb_card_slot_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/card_slot_sched_if.sv
// VGA timing bundle shared by the display pipeline stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblnk;
  logic        vblnk;
  logic        hsync;
  logic        vsync;

  modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
  modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/card_slot_sched.sv
// Round-robin card-slot scheduler: requesters fill a shadow hand table that is
// copied to the draw-facing active table once per frame on the vblnk rise.
module card_slot_sched #(
  parameter int MAX_CARDS = 5,
  parameter int CODE_W    = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  vga_if.in                           vga_in,
  input  logic                        player_req,
  input  logic [CODE_W-1:0]           player_code,
  output logic                        player_ack,
  input  logic                        dealer_req,
  input  logic [CODE_W-1:0]           dealer_code,
  output logic                        dealer_ack,
  input  logic                        clear,
  output logic [MAX_CARDS-1:0]        player_valid,
  output logic [MAX_CARDS*CODE_W-1:0] player_cards,
  output logic [MAX_CARDS-1:0]        dealer_valid,
  output logic [MAX_CARDS*CODE_W-1:0] dealer_cards,
  output logic                        player_full,
  output logic                        dealer_full,
  output logic                        frame_tick
);

  localparam int CNT_W = $clog2(MAX_CARDS + 1);
  localparam int TBL_W = MAX_CARDS * CODE_W;

  typedef enum logic {SIDE_PLAYER = 1'b0, SIDE_DEALER = 1'b1} side_e;

  side_e              r_rr_ptr;
  logic               r_vblnk_d;
  logic               r_p_ack, r_d_ack, r_frame_tick;
  logic [CNT_W-1:0]   r_p_cnt, r_d_cnt;
  logic [MAX_CARDS-1:0] r_p_sh_valid, r_d_sh_valid, r_p_act_valid, r_d_act_valid;
  logic [TBL_W-1:0]   r_p_sh_cards, r_d_sh_cards, r_p_act_cards, r_d_act_cards;

  logic w_p_full, w_d_full, w_p_elig, w_d_elig, w_gnt_p, w_gnt_d, w_commit;

  assign w_p_full = (r_p_cnt == CNT_W'(MAX_CARDS));
  assign w_d_full = (r_d_cnt == CNT_W'(MAX_CARDS));

  // The ack register doubles as a one-cycle mask so a req held through its ack
  // cycle cannot be granted twice.
  assign w_p_elig = player_req & ~w_p_full & ~r_p_ack & ~clear;
  assign w_d_elig = dealer_req & ~w_d_full & ~r_d_ack & ~clear;

  assign w_gnt_p  = w_p_elig & (~w_d_elig | (r_rr_ptr == SIDE_PLAYER));
  assign w_gnt_d  = w_d_elig & (~w_p_elig | (r_rr_ptr == SIDE_DEALER));

  assign w_commit = vga_in.vblnk & ~r_vblnk_d;

  // NOTE: every register below uses <= so all reads see pre-edge values; this is
  // what lets a commit coinciding with a grant or clear capture the old shadow.
  always_ff @(posedge clk) begin
    // NOTE: the hand tables are small register banks, not RAM, so they are
    // reset explicitly to give draw stages a defined empty table.
    if (rst) begin
      r_rr_ptr      <= SIDE_PLAYER;
      r_vblnk_d     <= 1'b0;
      r_p_ack       <= 1'b0;
      r_d_ack       <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_p_cnt       <= '0;
      r_d_cnt       <= '0;
      r_p_sh_valid  <= '0;
      r_d_sh_valid  <= '0;
      r_p_sh_cards  <= '0;
      r_d_sh_cards  <= '0;
      r_p_act_valid <= '0;
      r_d_act_valid <= '0;
      r_p_act_cards <= '0;
      r_d_act_cards <= '0;
    end else begin
      r_vblnk_d    <= vga_in.vblnk;
      r_p_ack      <= w_gnt_p;
      r_d_ack      <= w_gnt_d;
      r_frame_tick <= w_commit;

      if (w_gnt_p)      r_rr_ptr <= SIDE_DEALER;
      else if (w_gnt_d) r_rr_ptr <= SIDE_PLAYER;

      if (clear) begin
        r_p_cnt      <= '0;
        r_d_cnt      <= '0;
        r_p_sh_valid <= '0;
        r_d_sh_valid <= '0;
        r_p_sh_cards <= '0;
        r_d_sh_cards <= '0;
      end else begin
        if (w_gnt_p) begin
          for (int i = 0; i < MAX_CARDS; i++) begin
            if (CNT_W'(i) == r_p_cnt) begin
              r_p_sh_cards[i*CODE_W +: CODE_W] <= player_code;
              r_p_sh_valid[i]                  <= 1'b1;
            end
          end
          r_p_cnt <= r_p_cnt + CNT_W'(1);
        end
        if (w_gnt_d) begin
          for (int i = 0; i < MAX_CARDS; i++) begin
            if (CNT_W'(i) == r_d_cnt) begin
              r_d_sh_cards[i*CODE_W +: CODE_W] <= dealer_code;
              r_d_sh_valid[i]                  <= 1'b1;
            end
          end
          r_d_cnt <= r_d_cnt + CNT_W'(1);
        end
      end

      if (w_commit) begin
        r_p_act_valid <= r_p_sh_valid;
        r_d_act_valid <= r_d_sh_valid;
        r_p_act_cards <= r_p_sh_cards;
        r_d_act_cards <= r_d_sh_cards;
      end
    end
  end

  assign player_ack   = r_p_ack;
  assign dealer_ack   = r_d_ack;
  assign player_valid = r_p_act_valid;
  assign dealer_valid = r_d_act_valid;
  assign player_cards = r_p_act_cards;
  assign dealer_cards = r_d_act_cards;
  assign player_full  = w_p_full;
  assign dealer_full  = w_d_full;
  assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_card_slot_sched.sv
// Directed self-checking bench for card_slot_sched with hand-computed expectations.
module tb_card_slot_sched;

  localparam int MAX_CARDS = 5;
  localparam int CODE_W    = 6;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        player_req, dealer_req, clear;
  logic [CODE_W-1:0]           player_code, dealer_code;
  logic                        player_ack, dealer_ack;
  logic [MAX_CARDS-1:0]        player_valid, dealer_valid;
  logic [MAX_CARDS*CODE_W-1:0] player_cards, dealer_cards;
  logic                        player_full, dealer_full, frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  vga_if vga ();

  card_slot_sched #(.MAX_CARDS(MAX_CARDS), .CODE_W(CODE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .vga_in       (vga),
    .player_req   (player_req),
    .player_code  (player_code),
    .player_ack   (player_ack),
    .dealer_req   (dealer_req),
    .dealer_code  (dealer_code),
    .dealer_ack   (dealer_ack),
    .clear        (clear),
    .player_valid (player_valid),
    .player_cards (player_cards),
    .dealer_valid (dealer_valid),
    .dealer_cards (dealer_cards),
    .player_full  (player_full),
    .dealer_full  (dealer_full),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  // Lands #1 after the edge: inputs set now belong to this cycle, outputs are this cycle's.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_commit();
    vga.vblnk = 1'b1;
    tick();
    check("frame_tick_on_commit", 64'(frame_tick), 64'd1);
    vga.vblnk = 1'b0;
  endtask

  task automatic player_send(input logic [CODE_W-1:0] code);
    bit got = 1'b0;
    player_req  = 1'b1;
    player_code = code;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (player_ack) got = 1'b1;
    end
    check("player_send_acked", 64'(got), 64'd1);
    player_req = 1'b0;
  endtask

  task automatic dealer_send(input logic [CODE_W-1:0] code);
    bit got = 1'b0;
    dealer_req  = 1'b1;
    dealer_code = code;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (dealer_ack) got = 1'b1;
    end
    check("dealer_send_acked", 64'(got), 64'd1);
    dealer_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p_acks, d_acks, ack_seen;
    logic last_p, last_d;
    rst = 1'b1; player_req = 0; dealer_req = 0; clear = 0;
    player_code = '0; dealer_code = '0;
    vga.vblnk = 0; vga.hblnk = 0; vga.hsync = 0; vga.vsync = 0;
    vga.hcount = '0; vga.vcount = '0;

    // Reset state
    do_reset();
    check("rst_player_valid", 64'(player_valid), 64'd0);
    check("rst_dealer_valid", 64'(dealer_valid), 64'd0);
    check("rst_player_cards", 64'(player_cards), 64'd0);
    check("rst_acks", 64'({player_ack, dealer_ack}), 64'd0);
    check("rst_full_tick", 64'({player_full, dealer_full, frame_tick}), 64'd0);

    // Single grant, req held 2 cycles
    player_req = 1'b1; player_code = 6'h21;
    check("p_ack_same_cycle", 64'(player_ack), 64'd0);
    tick();
    check("p_ack_pulse", 64'(player_ack), 64'd1);
    tick();
    player_req = 1'b0;
    check("p_ack_one_cycle", 64'(player_ack), 64'd0);
    check("p_valid_before_commit", 64'(player_valid), 64'd0);
    tick();
    frame_commit();
    check("p_valid_after_commit", 64'(player_valid), 64'h01);
    check("p_slot0_code", 64'(player_cards[5:0]), 64'h21);
    tick();
    check("frame_tick_one_cycle", 64'(frame_tick), 64'd0);

    // Alternation with both requesting continuously
    do_reset();
    player_req = 1'b1; player_code = 6'h01;
    dealer_req = 1'b1; dealer_code = 6'h11;
    last_p = 0; last_d = 0; p_acks = 0; d_acks = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("alt_player_ack", 64'(player_ack), 64'(c % 2));
      check("alt_dealer_ack", 64'(dealer_ack), 64'((c + 1) % 2));
      check("alt_no_double_ack", 64'(player_ack & dealer_ack), 64'd0);
      check("alt_no_back_to_back", 64'((player_ack & last_p) | (dealer_ack & last_d)), 64'd0);
      last_p = player_ack; last_d = dealer_ack;
      if (player_ack) begin p_acks++; player_code = 6'h02; end
      if (dealer_ack) begin d_acks++; dealer_code = 6'h12; end
      if (c == 4) begin player_req = 1'b0; dealer_req = 1'b0; end
    end
    check("alt_ack_counts", 64'({p_acks[7:0], d_acks[7:0]}), 64'h0202);
    tick();
    frame_commit();
    check("alt_p_valid", 64'(player_valid), 64'h03);
    check("alt_p_cards", 64'(player_cards[11:0]), 64'h081);
    check("alt_d_valid", 64'(dealer_valid), 64'h03);
    check("alt_d_cards", 64'(dealer_cards[11:0]), 64'h491);

    // Fill the player hand, then a sixth request
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_full_off", 64'(player_full), 64'd0);
    for (int k = 0; k < 5; k++) player_send(CODE_W'(6'h20 + k));
    check("player_full_after5", 64'(player_full), 64'd1);
    player_req = 1'b1; player_code = 6'h3A;
    ack_seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (player_ack) ack_seen++;
    end
    check("sixth_no_ack", 64'(ack_seen), 64'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("full_cleared", 64'(player_full), 64'd0);
    check("no_ack_in_clear", 64'(player_ack), 64'd0);
    tick();
    check("sixth_acked", 64'(player_ack), 64'd1);
    player_req = 1'b0;
    tick();
    frame_commit();
    check("sixth_slot0_valid", 64'(player_valid), 64'h01);
    check("sixth_slot0_code", 64'(player_cards[5:0]), 64'h3A);
    check("dealer_cleared", 64'(dealer_valid), 64'd0);
    tick();

    // Grant in the same cycle as the vblnk rise
    player_req = 1'b1; player_code = 6'h05; vga.vblnk = 1'b1;
    tick();
    player_req = 1'b0; vga.vblnk = 1'b0;
    check("cg_ack", 64'(player_ack), 64'd1);
    check("cg_tick", 64'(frame_tick), 64'd1);
    check("cg_valid_unchanged", 64'(player_valid), 64'h01);
    tick();
    frame_commit();
    check("cg_valid_next", 64'(player_valid), 64'h03);
    check("cg_slot1_code", 64'(player_cards[11:6]), 64'h05);
    tick();

    // Clear with vblnk held high
    dealer_send(6'h15);
    tick();
    vga.vblnk = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("cc_tick", 64'(frame_tick), 64'd1);
    check("cc_p_old", 64'(player_valid), 64'h03);
    check("cc_d_old", 64'(dealer_valid), 64'h01);
    check("cc_d_code", 64'(dealer_cards[5:0]), 64'h15);
    for (int k = 0; k < 3; k++) tick();
    check("cc_no_recommit", 64'(frame_tick), 64'd0);
    check("cc_p_held", 64'(player_valid), 64'h03);
    vga.vblnk = 1'b0;
    tick();
    frame_commit();
    check("cc_p_empty", 64'(player_valid), 64'd0);
    check("cc_d_empty", 64'(dealer_valid), 64'd0);
    tick();

    // Reset mid-frame with a pending dealer request
    player_send(6'h07);
    tick();
    frame_commit();
    check("pre_rst_valid", 64'(player_valid), 64'h01);
    tick();
    dealer_req = 1'b1; dealer_code = 6'h19; rst = 1'b1;
    tick();
    check("mr_valid", 64'({player_valid, dealer_valid}), 64'd0);
    check("mr_cards", 64'(player_cards | dealer_cards), 64'd0);
    check("mr_flags", 64'({player_ack, dealer_ack, player_full, dealer_full, frame_tick}), 64'd0);
    tick();
    check("mr_no_dealer_ack", 64'(dealer_ack), 64'd0);
    rst = 1'b0; player_req = 1'b1; player_code = 6'h08;
    check("mr_no_dealer_ack2", 64'(dealer_ack), 64'd0);
    tick();
    check("mr_first_player", 64'(player_ack), 64'd1);
    check("mr_first_not_dealer", 64'(dealer_ack), 64'd0);
    player_req = 1'b0; dealer_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
